// File: rtl/approx_fir_pipe.sv
// approx_fir_pipe: shift-coefficient FIR with a chain of lower-part-approximate Kogge-Stone adders.
// Optional FIR_WARMUP_EN holds off out_valid until the delay line holds TAPS samples.
module approx_fir_pipe #(
    parameter int W = 16,
    parameter int TAPS = 5,
    parameter int K = 2,
    parameter logic [4*TAPS-1:0] SHIFTS = 20'h12345
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] x,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] dout
);
    localparam int KI = (K > 0) ? K - 1 : 0;
    localparam logic [W-1:0] LOW_M = W'((64'd1 << K) - 64'd1);

    // Low K bits add without carry propagation; only a[K-1]&b[K-1] feeds the exact upper part.
    function automatic logic [W-1:0] ax(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] ua, ub, p, pp, g, gn, pn;
        logic cin;
        cin = (K > 0) && a[KI] && b[KI];
        ua = a >> K;
        ub = b >> K;
        p = ua ^ ub;
        pp = p;
        g = (ua & ub) | {{(W-1){1'b0}}, p[0] & cin};
        for (int d = 1; d < W; d = d * 2) begin
            gn = g;
            pn = pp;
            for (int i = d; i < W; i++) begin
                gn[i] = g[i] | (pp[i] & g[i-d]);
                pn[i] = pp[i] & pp[i-d];
            end
            g = gn;
            pp = pn;
        end
        return ((p ^ {g[W-2:0], cin}) << K) | ((a + b) & LOW_M);
    endfunction

    logic [TAPS-1:1][W-1:0] dl_q, dl_d;
    logic [W-1:0] dout_q, dout_d, acc;
    logic out_valid_q, out_valid_d;
    logic accept, emit;

    assign in_ready = !out_valid_q | out_ready;
    assign accept = in_valid & in_ready;
    assign out_valid = out_valid_q;
    assign dout = dout_q;

    always_comb begin
        acc = x >> SHIFTS[3:0];
        for (int i = 1; i < TAPS; i++)
            acc = ax(acc, dl_q[i] >> SHIFTS[4*i +: 4]);
    end

    always_comb begin
        dl_d = dl_q;
        if (accept) begin
            dl_d[1] = x;
            for (int i = 2; i < TAPS; i++)
                dl_d[i] = dl_q[i-1];
        end
    end

    assign dout_d = accept ? acc : dout_q;
    assign out_valid_d = accept ? emit : (out_valid_q & !out_ready);

`ifdef FIR_WARMUP_EN
    localparam int CW = $clog2(TAPS);
    logic [CW-1:0] cnt_q, cnt_d;
    assign emit = (cnt_q == CW'(TAPS - 1));
    assign cnt_d = (accept && !emit) ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end
`else
    assign emit = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dl_q        <= '0;
            dout_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            dl_q        <= dl_d;
            dout_q      <= dout_d;
            out_valid_q <= out_valid_d;
        end
    end
endmodule

// File: tb/tb_approx_fir_pipe.sv
// tb_approx_fir_pipe: directed checks of the default filter plus two TAPS=2 instances (K=2 and K=0).
module tb_approx_fir_pipe;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic in_valid = 1'b0;
    logic in_ready;
    logic [15:0] x = '0;
    logic out_valid;
    logic out_ready = 1'b1;
    logic [15:0] dout;
    logic a_valid = 1'b0;
    logic [15:0] a_x = '0;
    logic a_oready = 1'b1;
    logic k2_ready, k0_ready, k2_ov, k0_ov;
    logic [15:0] k2_dout, k0_dout;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    approx_fir_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x(x),
        .out_valid(out_valid), .out_ready(out_ready), .dout(dout)
    );

    approx_fir_pipe #(.W(16), .TAPS(2), .K(2), .SHIFTS(8'h00)) u_k2 (
        .clk(clk), .rst(rst), .in_valid(a_valid), .in_ready(k2_ready), .x(a_x),
        .out_valid(k2_ov), .out_ready(a_oready), .dout(k2_dout)
    );

    approx_fir_pipe #(.W(16), .TAPS(2), .K(0), .SHIFTS(8'h00)) u_k0 (
        .clk(clk), .rst(rst), .in_valid(a_valid), .in_ready(k0_ready), .x(a_x),
        .out_valid(k0_ov), .out_ready(a_oready), .dout(k0_dout)
    );

    task automatic push(input logic [15:0] v);
        in_valid = 1'b1;
        x = v;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        in_valid = 1'b1;
        x = 16'hFFFF;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (dout !== 16'h0) begin errors++; $display("FAIL reset_dout got=%h exp=0000", dout); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
        in_valid = 1'b0;
        rst = 1'b1;
        push(16'h0000);
        checks++; if (dout !== 16'h0) begin errors++; $display("FAIL reset_first_dout got=%h exp=0000", dout); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL reset_first_valid got=%b exp=1", out_valid); end
    endtask

    task automatic test_impulse;
        logic [15:0] feed [6] = '{16'h8000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        logic [15:0] expv [6] = '{16'h0400, 16'h0800, 16'h1000, 16'h2000, 16'h4000, 16'h0000};
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            push(feed[i]);
            checks++;
            if (dout !== expv[i] || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL impulse[%0d] got=%h/%b exp=%h/1", i, dout, out_valid, expv[i]);
            end
        end
    endtask

    task automatic test_idle;
        @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_backpressure;
        logic [15:0] expv [4] = '{16'h0800, 16'h1000, 16'h2000, 16'h4000};
        out_ready = 1'b1;
        push(16'h8000);
        checks++; if (dout !== 16'h0400) begin errors++; $display("FAIL bp_first got=%h exp=0400", dout); end
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            x = i[0] ? 16'h1234 : 16'hFFFF;
            #1;
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d] got=%b exp=0", i, in_ready); end
            @(posedge clk);
            #1;
            checks++;
            if (dout !== 16'h0400 || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold[%0d] got=%h/%b exp=0400/1", i, dout, out_valid);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push(16'h0000);
            checks++; if (dout !== expv[i]) begin errors++; $display("FAIL bp_resume[%0d] got=%h exp=%h", i, dout, expv[i]); end
        end
    endtask

    task automatic test_midreset;
        out_ready = 1'b1;
        push(16'h8000);
        push(16'h0000);
        checks++; if (dout !== 16'h0800) begin errors++; $display("FAIL mr_second got=%h exp=0800", dout); end
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (dout !== 16'h0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mr_async got=%h/%b exp=0000/0", dout, out_valid);
        end
        rst = 1'b1;
        push(16'h0000);
        checks++;
        if (dout !== 16'h0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL mr_after got=%h/%b exp=0000/1", dout, out_valid);
        end
    endtask

    task automatic test_approx;
        logic [15:0] feed [6] = '{16'd3, 16'd1, 16'd2, 16'd3, 16'd1, 16'hFFFF};
        logic [15:0] e2 [6] = '{16'd3, 16'd0, 16'd3, 16'd5, 16'd0, 16'hFFFC};
        logic [15:0] e0 [6] = '{16'd3, 16'd4, 16'd3, 16'd5, 16'd4, 16'h0000};
        for (int i = 0; i < 6; i++) begin
            a_valid = 1'b1;
            a_x = feed[i];
            @(posedge clk);
            #1;
            checks++; if (k2_dout !== e2[i]) begin errors++; $display("FAIL approx_k2[%0d] got=%h exp=%h", i, k2_dout, e2[i]); end
            checks++; if (k0_dout !== e0[i]) begin errors++; $display("FAIL approx_k0[%0d] got=%h exp=%h", i, k0_dout, e0[i]); end
        end
        a_valid = 1'b0;
    endtask

    task automatic test_warmup;
        logic [15:0] feed [5] = '{16'h8000, 16'h0, 16'h0, 16'h0, 16'h0};
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push(feed[i]);
            checks++;
            if (out_valid !== (i == 4)) begin
                errors++;
                $display("FAIL warm_valid[%0d] got=%b exp=%b", i, out_valid, i == 4);
            end
        end
        checks++; if (dout !== 16'h4000) begin errors++; $display("FAIL warm_dout got=%h exp=4000", dout); end
        push(16'h0000);
        checks++;
        if (dout !== 16'h0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL warm_next got=%h/%b exp=0000/1", dout, out_valid);
        end
    endtask

    initial begin
`ifdef FIR_WARMUP_EN
        test_warmup;
`else
        test_reset;
        test_impulse;
        test_idle;
        test_backpressure;
        test_midreset;
        test_approx;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
